// File: rtl/freq_calc.sv
`default_nettype none
// ============================================================================
//  Module   : freq_calc
//  Purpose  : f_meas = meas_cnt * F_REF_HZ / ref_cnt in unsigned fixed point
//             (FRAC_W fractional bits) via a multi-cycle restoring divider.
//             Optional round-to-nearest build: define FREQ_CALC_ROUND_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module freq_calc #(
    parameter logic [31:0] F_REF_HZ = 32'd10_000_000,
    parameter int          CNT_W    = 32,
    parameter int          FRAC_W   = 8,
    parameter int          OUT_W    = 32
) (
    input  logic             clk_ref,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] ref_cnt,
    input  logic [CNT_W-1:0] meas_cnt,
    output logic             out_valid,
    output logic [OUT_W-1:0] freq_out,
    output logic             err_div0,
    output logic             err_ovf
);

    localparam int c_div_w    = CNT_W + 32 + FRAC_W + 1;
    localparam int c_cnt_bits = $clog2(c_div_w);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_div  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [CNT_W-1:0]      r_ref;
    logic [CNT_W-1:0]      r_meas;
    logic [c_div_w-1:0]    r_dividend;
    logic [CNT_W:0]        r_rem;
    logic [c_cnt_bits-1:0] r_cnt;
    logic [OUT_W-1:0]      r_freq;
    logic                  r_div0;
    logic                  r_ovf;
    logic                  r_out_valid;

    logic [c_div_w-1:0]    w_product;
    logic [c_div_w-1:0]    w_round;
    logic [c_div_w-1:0]    w_dividend;
    logic [CNT_W:0]        w_rem_shift;
    logic                  w_ge;
    logic [CNT_W:0]        w_rem_next;
    logic [c_div_w-1:0]    w_quot_next;
    logic                  w_sat;

    assign w_product = c_div_w'(r_meas) * c_div_w'(F_REF_HZ);

`ifdef FREQ_CALC_ROUND_EN
    assign w_round = c_div_w'(r_ref >> 1);
`else
    assign w_round = '0;
`endif

    assign w_dividend = (w_product << FRAC_W) + w_round;

    // Dividend register doubles as quotient shift register: dividend bits leave
    // at the MSB while quotient bits enter at the LSB.
    assign w_rem_shift = {r_rem[CNT_W-1:0], r_dividend[c_div_w-1]};
    assign w_ge        = r_rem[CNT_W] || (w_rem_shift >= {1'b0, r_ref});
    assign w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_ref}) : w_rem_shift;
    assign w_quot_next = {r_dividend[c_div_w-2:0], w_ge};
    assign w_sat       = |(w_quot_next >> OUT_W);

    always_ff @(posedge clk_ref) begin
        if (sys_rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: if (in_valid) w_state_next = c_mul;
            c_mul:  w_state_next = (r_ref == '0) ? c_done : c_div;
            c_div:  if (r_cnt == '0) w_state_next = c_done;
            c_done: w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    // Result registers are loaded on the edge entering DONE so they are
    // already valid during the out_valid cycle and hold until the next DONE.
    always_ff @(posedge clk_ref) begin
        if (sys_rst) begin
            r_ref       <= '0;
            r_meas      <= '0;
            r_dividend  <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_freq      <= '0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_ref  <= ref_cnt;
                        r_meas <= meas_cnt;
                    end
                end
                c_mul: begin
                    r_dividend <= w_dividend;
                    r_rem      <= '0;
                    r_cnt      <= c_cnt_bits'(c_div_w - 1);
                    if (r_ref == '0) begin
                        r_freq      <= '0;
                        r_div0      <= 1'b1;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                c_div: begin
                    r_dividend <= w_quot_next;
                    r_rem      <= w_rem_next;
                    r_cnt      <= r_cnt - c_cnt_bits'(1);
                    if (r_cnt == '0) begin
                        r_freq      <= w_sat ? '1 : w_quot_next[OUT_W-1:0];
                        r_div0      <= 1'b0;
                        r_ovf       <= w_sat;
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = r_out_valid;
    assign freq_out  = r_freq;
    assign err_div0  = r_div0;
    assign err_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_freq_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_calc
//  Purpose  : Self-checking bench for freq_calc with a wide-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_calc;

    localparam int      CNT_W  = 32;
    localparam int      FRAC_W = 8;
    localparam int      OUT_W  = 32;
    localparam longint  F_REF  = 10_000_000;
    localparam int      DIV_W  = CNT_W + 32 + FRAC_W + 1;

    logic              clk_ref = 1'b0;
    logic              sys_rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CNT_W-1:0]  ref_cnt = '0;
    logic [CNT_W-1:0]  meas_cnt = '0;
    logic              out_valid;
    logic [OUT_W-1:0]  freq_out;
    logic              err_div0;
    logic              err_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    freq_calc dut (
        .clk_ref  (clk_ref),
        .sys_rst  (sys_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ref_cnt  (ref_cnt),
        .meas_cnt (meas_cnt),
        .out_valid(out_valid),
        .freq_out (freq_out),
        .err_div0 (err_div0),
        .err_ovf  (err_ovf)
    );

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    // Reference: exact integer arithmetic on 128-bit values.
    function automatic void model(input logic [31:0] r, input logic [31:0] m,
                                  output logic [31:0] f, output logic d0, output logic ov);
        logic [127:0] num;
        logic [127:0] q;
        if (r == 0) begin
            f = 0; d0 = 1'b1; ov = 1'b0;
        end else begin
            num = (128'(m) * 128'(F_REF)) << FRAC_W;
`ifdef FREQ_CALC_ROUND_EN
            num = num + 128'(r / 2);
`endif
            q = num / 128'(r);
            d0 = 1'b0;
            if (q > 128'h0000_0000_FFFF_FFFF) begin
                f = 32'hFFFF_FFFF; ov = 1'b1;
            end else begin
                f = q[31:0]; ov = 1'b0;
            end
        end
    endfunction

    task automatic run_txn(input logic [31:0] r, input logic [31:0] m,
                           input logic [31:0] ef, input logic ed, input logic eo,
                           input string tag);
        int n;
        int t0;
        int exp_lat;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk_ref); n++; end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s ready_timeout: in_ready=%b required 1", tag, in_ready);
        else n_pass++;
        ref_cnt = r; meas_cnt = m; in_valid = 1'b1; t0 = cyc;
        @(negedge clk_ref);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin @(negedge clk_ref); n++; end
        exp_lat = (r == 0) ? 2 : DIV_W + 2;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s valid_timeout: out_valid=%b required 1", tag, out_valid);
        else n_pass++;
        n_checks++;
        if ((cyc - t0) !== exp_lat) $display("FAIL %s latency: got %0d required %0d", tag, cyc - t0, exp_lat);
        else n_pass++;
        n_checks++;
        if (freq_out !== ef) $display("FAIL %s freq_out: got %0d required %0d", tag, freq_out, ef);
        else n_pass++;
        n_checks++;
        if (err_div0 !== ed || err_ovf !== eo)
            $display("FAIL %s flags: div0=%b ovf=%b required div0=%b ovf=%b", tag, err_div0, err_ovf, ed, eo);
        else n_pass++;
        @(negedge clk_ref);
        n_checks++;
        if (out_valid !== 1'b0 || freq_out !== ef)
            $display("FAIL %s pulse_hold: out_valid=%b freq_out=%0d required 0 and %0d", tag, out_valid, freq_out, ef);
        else n_pass++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk_ref);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || freq_out !== '0 || err_div0 !== 1'b0 || err_ovf !== 1'b0)
            $display("FAIL reset_state: ready=%b valid=%b freq=%0d div0=%b ovf=%b required 1 0 0 0 0",
                     in_ready, out_valid, freq_out, err_div0, err_ovf);
        else n_pass++;
        sys_rst = 1'b0;
        @(negedge clk_ref);
    endtask

    task automatic test_directed();
        run_txn(32'd10_000_000, 32'd1_000_000, 32'd256_000_000, 1'b0, 1'b0, "nominal");
        run_txn(32'd600_000, 32'd60_000, 32'd256_000_000, 1'b0, 1'b0, "short_gate");
`ifdef FREQ_CALC_ROUND_EN
        run_txn(32'd600_000, 32'd60_001, 32'd256_004_267, 1'b0, 1'b0, "short_gate_frac");
        run_txn(32'd7, 32'd1, 32'd365_714_286, 1'b0, 1'b0, "rounding");
`else
        run_txn(32'd600_000, 32'd60_001, 32'd256_004_266, 1'b0, 1'b0, "short_gate_frac");
        run_txn(32'd7, 32'd1, 32'd365_714_285, 1'b0, 1'b0, "rounding");
`endif
        run_txn(32'd1, 32'd1000, 32'hFFFF_FFFF, 1'b0, 1'b1, "overflow");
        run_txn(32'd0, 32'd5, 32'd0, 1'b1, 1'b0, "div0");
        run_txn(32'd12345, 32'd0, 32'd0, 1'b0, 1'b0, "meas_zero");
    endtask

    task automatic test_random();
        logic [31:0] r, m, ef;
        logic ed, eo;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: r = $urandom_range(0, 15);
                1: r = $urandom;
                default: r = $urandom_range(1_000_000, 20_000_000);
            endcase
            case ($urandom_range(0, 2))
                0: m = $urandom_range(0, 15);
                1: m = $urandom;
                default: m = (r >> $urandom_range(0, 8)) + $urandom_range(0, 3);
            endcase
            model(r, m, ef, ed, eo);
            run_txn(r, m, ef, ed, eo, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [1:0]  flg_q[$];
        logic [31:0] ef;
        logic ed, eo;
        int accepted, produced, last_acc, cycles;
        bit pending;
        accepted = 0; produced = 0; last_acc = -1; cycles = 0; pending = 0;
        ref_cnt = $urandom_range(1000, 50_000_000);
        meas_cnt = $urandom_range(0, 5_000_000);
        in_valid = 1'b1;
        while (produced < 4 && cycles < 1000) begin
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra_valid: out_valid=1 with no accepted pair outstanding");
                end else begin
                    ef = exp_q.pop_front();
                    {ed, eo} = flg_q.pop_front();
                    if (freq_out !== ef || err_div0 !== ed || err_ovf !== eo)
                        $display("FAIL b2b_result%0d: freq=%0d div0=%b ovf=%b required %0d %b %b",
                                 produced, freq_out, err_div0, err_ovf, ef, ed, eo);
                    else n_pass++;
                end
                produced++;
            end
            if (pending) begin
                pending = 0;
                if (accepted == 4) in_valid = 1'b0;
                ref_cnt = $urandom_range(1000, 50_000_000);
                meas_cnt = $urandom_range(0, 5_000_000);
            end
            if (in_valid && in_ready) begin
                model(ref_cnt, meas_cnt, ef, ed, eo);
                exp_q.push_back(ef);
                flg_q.push_back({ed, eo});
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc !== DIV_W + 3)
                        $display("FAIL b2b_accept_gap: got %0d required %0d", cyc - last_acc, DIV_W + 3);
                    else n_pass++;
                end
                last_acc = cyc;
                accepted++;
                pending = 1;
            end
            @(negedge clk_ref);
            cycles++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (produced !== 4 || accepted !== 4 || exp_q.size() !== 0)
            $display("FAIL b2b_count: produced=%0d accepted=%0d left=%0d required 4 4 0",
                     produced, accepted, exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_reset_mid();
        bit seen;
        run_txn(32'd600_000, 32'd60_000, 32'd256_000_000, 1'b0, 1'b0, "pre_reset");
        seen = 0;
        ref_cnt = 32'd10_000_000; meas_cnt = 32'd1_000_000; in_valid = 1'b1;
        @(negedge clk_ref);
        in_valid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk_ref);
            if (out_valid) seen = 1;
        end
        sys_rst = 1'b1;
        @(negedge clk_ref);
        n_checks++;
        if (out_valid !== 1'b0 || freq_out !== '0 || err_div0 !== 1'b0 || err_ovf !== 1'b0)
            $display("FAIL midrst_outputs: valid=%b freq=%0d div0=%b ovf=%b required all 0",
                     out_valid, freq_out, err_div0, err_ovf);
        else n_pass++;
        sys_rst = 1'b0;
        @(negedge clk_ref);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midrst_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) seen = 1;
            @(negedge clk_ref);
        end
        n_checks++;
        if (seen || freq_out !== '0)
            $display("FAIL midrst_no_valid: seen_valid=%0d freq=%0d required 0 0", seen, freq_out);
        else n_pass++;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_ref);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/freq_calc.md
Name: freq_calc

Overview:
- Downstream of the reciprocal frequency meter: consumes one latched (reference-count, measured-count) pair per gate window.
- Computes f_meas = meas_cnt * F_REF_HZ / ref_cnt as an unsigned fixed-point value with FRAC_W fractional bits.
- Uses a multi-cycle restoring divider, so no combinational divide sits in the clk_ref domain.
- Result goes to the readout/UART stage with a one-cycle valid strobe plus error flags.

Parameters:
- F_REF_HZ, 10_000_000, reference clock frequency in Hz; must fit in 32 bits.
- CNT_W, 32, width of ref_cnt and meas_cnt.
- FRAC_W, 8, fractional bits of the result (Hz * 2^FRAC_W).
- OUT_W, 32, width of freq_out.
- Derived, not overridable: DIV_W = CNT_W + 32 + FRAC_W + 1 (dividend width; divider iteration count).

Ports:
- clk_ref  in  1  system clock, the reference clock domain.
- sys_rst  in  1  synchronous reset, active-high.
- in_valid  in  1  count pair valid.
- in_ready  out  1  block idle, can accept a pair.
- ref_cnt  in  CNT_W  reference-clock cycles counted in the gate window.
- meas_cnt  in  CNT_W  measured-clock cycles counted in the gate window.
- out_valid  out  1  one-cycle result strobe.
- freq_out  out  OUT_W  frequency in Hz, unsigned, FRAC_W fractional bits.
- err_div0  out  1  last result had ref_cnt == 0.
- err_ovf  out  1  last result saturated.

Behaviour:
- Interface: single clock clk_ref; sys_rst is synchronous, active-high. All state is updated on the rising edge of clk_ref.
- Reset values: in_ready=1, out_valid=0, freq_out=0, err_div0=0, err_ovf=0, FSM=IDLE.
- Handshake:
  - A transfer occurs on a cycle where in_valid && in_ready; ref_cnt and meas_cnt are captured on that cycle.
  - in_ready=1 only in IDLE.
  - in_valid while busy is ignored (not queued).
- FSM states:
  - IDLE: on transfer -> MUL.
  - MUL, 1 cycle: dividend D = meas_cnt * F_REF_HZ * 2^FRAC_W (+ rounding term, see optional feature), zero-extended to DIV_W. Divisor = ref_cnt. If ref_cnt==0 -> DONE with div0 set; else -> DIV.
  - DIV, exactly DIV_W cycles: restoring division, one quotient bit per cycle, MSB first, with a remainder register of CNT_W+1 bits. -> DONE.
  - DONE, 1 cycle: drive outputs, pulse out_valid. -> IDLE.
- Latency:
  - Transfer at cycle T gives out_valid at T+DIV_W+2 (T+75 with defaults).
  - Div0 case gives out_valid at T+2.
  - in_ready returns high the cycle after out_valid.
- Arithmetic:
  - The quotient is DIV_W bits.
  - If any bit above OUT_W-1 is set: freq_out = all ones, err_ovf=1. Otherwise freq_out = quotient[OUT_W-1:0], err_ovf=0.
- Div0: freq_out=0, err_div0=1, err_ovf=0.
- meas_cnt==0 with ref_cnt!=0: freq_out=0, no error.
- Output holding:
  - freq_out, err_div0 and err_ovf are updated only in DONE and hold until the next DONE.
  - out_valid is high for exactly one cycle per accepted pair.
- Reset mid-operation: sys_rst in any state aborts the computation with no out_valid. All outputs return to reset values on the next edge; in_ready=1 the cycle after sys_rst deasserts.
- Simultaneous in_valid with the DONE cycle: not accepted (in_ready=0). It is accepted in the following IDLE cycle if still asserted.

Optional Feature:
- FREQ_CALC_ROUND_EN defined: in MUL, D = meas_cnt*F_REF_HZ*2^FRAC_W + (ref_cnt>>1), so the result is rounded to nearest (ties up).
- Not defined: no rounding term; the result is truncated (floor).
- Latency, saturation and div0 behaviour are identical in both builds.

Test Plan:
- Nominal, defaults: ref_cnt=10_000_000, meas_cnt=1_000_000 -> freq_out=256_000_000 (1 MHz), no errors; out_valid exactly 75 cycles after transfer.
- Short gate: ref_cnt=600_000, meas_cnt=60_000 -> freq_out=256_000_000; then ref_cnt=600_000, meas_cnt=60_001 -> freq_out=256_004_266 (floor of 256_004_266.67).
- Rounding: ref_cnt=7, meas_cnt=1 -> freq_out=365_714_285 without FREQ_CALC_ROUND_EN and 365_714_286 with it.
- Errors:
  - ref_cnt=1, meas_cnt=1000 -> freq_out=0xFFFF_FFFF, err_ovf=1.
  - Then ref_cnt=0, meas_cnt=5 -> freq_out=0, err_div0=1, err_ovf=0, out_valid at T+2.
- Busy/reset:
  - Hold in_valid high continuously -> pairs accepted only when in_ready=1, one out_valid per accepted pair.
  - Assert sys_rst 20 cycles into DIV -> no out_valid, all outputs 0, in_ready=1 after release.
